// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSN   = 32'h0000_0000;
    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 27;
    localparam int          IMEM_AW    = 12;

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        BUBBLE = 2'b10
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        valid;
    } fd_entry_t;

    localparam fd_entry_t FD_BUBBLE = '{insn: NOP_INSN, pc: 32'd0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_fd_latch.sv
// F/D pipeline register: bubble load beats hold, hold beats capture.
module fd_latch
    import fetch_stage_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      hold,
    input  logic      load_bubble,
    input  fd_entry_t d,
    output fd_entry_t q
);

    always_ff @(posedge clock) begin
        if (!reset_n)
            q <= FD_BUBBLE;
        else if (load_bubble)
            q <= FD_BUBBLE;
        else if (!hold)
            q <= d;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BOOT/RUN/BUBBLE sequencing, F/D latch and squash counter.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic [31:0]          imem_q,
    output logic [IMEM_AW-1:0]   imem_addr,
    output logic [31:0]          fd_insn,
    output logic [31:0]          fd_pc,
    output logic                 fd_valid,
    output logic [4:0]           fd_opcode,
    output logic [15:0]          flush_count
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_inc;
    logic         in_boot;
    logic         squash;
    fd_entry_t    fd_d;
    fd_entry_t    fd_q;

    assign pc_inc    = pc + 32'd1;
    assign imem_addr = pc[IMEM_AW-1:0];
    assign in_boot   = (state == BOOT);
    // Redirects are ignored while booting; otherwise they override stall.
    assign squash    = !in_boot && redirect_valid;

    assign fd_d = '{insn: imem_q, pc: pc_inc, valid: 1'b1};

    fd_latch u_fd_latch (
        .clock       (clock),
        .reset_n     (reset_n),
        .hold        (stall),
        .load_bubble (in_boot || squash),
        .d           (fd_d),
        .q           (fd_q)
    );

    assign fd_insn   = fd_q.insn;
    assign fd_pc     = fd_q.pc;
    assign fd_valid  = fd_q.valid;
    assign fd_opcode = fd_q.insn[OPCODE_MSB:OPCODE_LSB];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= BOOT;
            pc          <= 32'd0;
            flush_count <= 16'd0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN, BUBBLE: begin
                    if (squash) begin
                        pc    <= redirect_pc;
                        state <= BUBBLE;
                        if (flush_count != 16'hFFFF)
                            flush_count <= flush_count + 16'd1;
                    end else if (!stall) begin
                        pc    <= pc_inc;
                        state <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-003 stall  input  1  decode/hazard hold request; 1 = freeze PC and F/D latch.
REQ-004 redirect_valid  input  1  taken branch/jump/jr/bex resolved downstream; squash and refetch.
REQ-005 redirect_pc  input  32  target PC, qualified by redirect_valid.
REQ-006 imem_q  input  32  instruction memory read data; combinational from imem_addr, same cycle.
REQ-007 imem_addr  output  12  instruction memory word address = pc[11:0].
REQ-008 fd_insn  output  32  F/D latched instruction.
REQ-009 fd_pc  output  32  F/D latched PC+1 of fd_insn (link/branch base).
REQ-010 fd_valid  output  1  1 = fd_insn is a real instruction, 0 = bubble.
REQ-011 fd_opcode  output  5  fd_insn[31:27], drives the opcode decoder directly.
REQ-012 flush_count  output  16  saturating count of redirect squashes since reset.

Function
REQ-013 Internal pc register, 32 bits; pc+1 computed modulo 2^32 (0xFFFFFFFF -> 0x00000000); imem_addr wraps 4095 -> 0.
REQ-014 Bubble encoding: fd_insn = 32'h00000000 (decodes as r-type add $0,$0,$0), fd_pc = 0, fd_valid = 0.
REQ-015 FSM states: BOOT, RUN, BUBBLE; state register is internal.
REQ-016 BOOT: entered on reset; F/D holds bubble; pc not advanced; next state RUN unconditionally (stall ignored).
REQ-017 RUN, no redirect, stall=0: pc <= pc+1; fd_insn <= imem_q; fd_pc <= pc+1; fd_valid <= 1; stay RUN.
REQ-018 RUN or BUBBLE, stall=1, no redirect: pc, F/D latch, and state unchanged.
REQ-019 Any state except BOOT, redirect_valid=1: pc <= redirect_pc; F/D <= bubble; next state BUBBLE; flush_count += 1, saturating at 0xFFFF.
REQ-020 Priority: reset > redirect > stall > normal advance; redirect with stall=1 is a redirect.
REQ-021 BUBBLE, no redirect, stall=0: same as REQ-017 (fetch from redirected pc), next state RUN.
REQ-022 Back-to-back redirects: each taken; last target wins; F/D stays bubble; count increments each cycle.
REQ-023 Fetch-to-F/D latency one cycle; redirect-to-first-valid fd_insn two edges (squash edge + fetch edge).
REQ-024 fd_opcode purely combinational from fd_insn; no other output has a combinational path from any input except imem_addr from pc.

Reset
REQ-025 reset_n=0 at a rising edge: pc <= 0, F/D <= bubble, flush_count <= 0, state <= BOOT, regardless of stall/redirect.
REQ-026 Reset asserted mid-stall or mid-redirect discards all pending effects; first valid fd_insn is imem word 0, two edges after reset_n rises.
REQ-027 Outputs during reset: imem_addr=0, fd_insn=0, fd_pc=0, fd_valid=0, fd_opcode=0, flush_count=0.

Structure
REQ-028 Shared package: NOP_INSN (32'h0), OPCODE_MSB/LSB (31/27), IMEM_AW (12), FSM state encoding (BOOT=2'b00, RUN=2'b01, BUBBLE=2'b10).
REQ-029 One sub-module: fd_latch (32+32+1 bit register with hold enable and synchronous bubble load); pc, adder, FSM, counter in fetch_stage.

Verification
REQ-030 Reset then 4 free-run cycles, imem[n]=0x1000_0000+n -> after edge 2 fd_insn=0x10000000, fd_pc=1, fd_valid=1; imem_addr 0,0,1,2,3.
REQ-031 Stall high 3 cycles while fd_insn=imem[2] -> fd_insn, fd_pc=3, imem_addr=3 held; release -> fd_insn=imem[3] next edge.
REQ-032 redirect_valid with redirect_pc=0x40 and stall=1 -> next edge fd_valid=0, fd_insn=0, imem_addr=0x040, flush_count=1; following edge fd_pc=0x41.
REQ-033 pc forced via redirect to 0xFFFFFFFF -> after fetch fd_pc=0x00000000, imem_addr 0xFFF then 0x000.
REQ-034 reset_n low during BUBBLE with redirect_valid=1 -> pc=0, flush_count=0, state BOOT; 65536 redirects -> flush_count stays 0xFFFF.
